// File: rtl/dm_access_ctrl_if.sv
// Request/response bundle between the execute stage (master) and the
// data-memory access controller (slave).
interface dm_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_signed, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: turns byte/half/word/dword load/store
// requests into whole-doubleword DM transactions. Sub-doubleword stores run
// as read-modify-write; loads are lane-extracted and sign/zero extended.
// Optional feature macro: DM_MISALIGN_TRAP_EN (misaligned accesses error out
// instead of having their low offset bits forced to zero).
module dm_access_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    dm_access_ctrl_if.slave   bus,
    output logic [11:0]       dm_direccion,
    output logic [DATA_W-1:0] dm_dataWrite,
    output logic              dm_enableWr,
    output logic              dm_bitAddress,
    input  logic [DATA_W-1:0] dm_dataRead
);

    typedef enum logic [2:0] {IDLE, LOAD, RD_OLD, WRITE, RESP} state_t;

    state_t             state_q, state_d;
    logic [2:0]         off_q, off_d;
    logic [1:0]         size_q, size_d;
    logic               signed_q, signed_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               req_ready_q, req_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]  resp_rdata_q, resp_rdata_d;
    logic               resp_err_q, resp_err_d;
    logic [11:0]        dm_direccion_q, dm_direccion_d;
    logic [DATA_W-1:0]  dm_dataWrite_q, dm_dataWrite_d;
    logic               dm_bitAddress_q, dm_bitAddress_d;
    logic               err_s;
    logic [2:0]         req_off_s;

    // Byte-lane enables for an access of 1<<size bytes starting at byte off.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    // Widen a per-byte enable into a per-bit mask.
    function automatic logic [63:0] expand_mask(input logic [7:0] m);
        logic [63:0] r;
        r = 64'h0;
        for (int k = 0; k < 8; k++) begin
            r[8*k +: 8] = {8{m[k]}};
        end
        return r;
    endfunction

    // Offset rounded down to the natural alignment of the access size.
    function automatic logic [2:0] align_off(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'd0:    return off;
            2'd1:    return {off[2:1], 1'b0};
            2'd2:    return {off[2], 2'b00};
            default: return 3'b000;
        endcase
    endfunction

    // Keep the low 1<<size bytes of a right-aligned value, then extend.
    function automatic logic [63:0] extend(input logic [63:0] raw, input logic [1:0] size,
                                           input logic sgn);
        case (size)
            2'd0:    return sgn ? {{56{raw[7]}},  raw[7:0]}  : {56'h0, raw[7:0]};
            2'd1:    return sgn ? {{48{raw[15]}}, raw[15:0]} : {48'h0, raw[15:0]};
            2'd2:    return sgn ? {{32{raw[31]}}, raw[31:0]} : {32'h0, raw[31:0]};
            default: return raw;
        endcase
    endfunction

    // Request decode: region check plus the build-selected alignment policy.
    always_comb begin
`ifdef DM_MISALIGN_TRAP_EN
        req_off_s = bus.req_addr[2:0];
        err_s     = !bus.req_addr[ADDR_W-1] ||
                    (align_off(bus.req_size, bus.req_addr[2:0]) != bus.req_addr[2:0]);
`else
        req_off_s = align_off(bus.req_size, bus.req_addr[2:0]);
        err_s     = !bus.req_addr[ADDR_W-1];
`endif
    end

    // Next-state and next-output logic of the access FSM.
    always_comb begin
        state_d         = state_q;
        off_d           = off_q;
        size_d          = size_q;
        signed_d        = signed_q;
        wdata_d         = wdata_q;
        resp_rdata_d    = resp_rdata_q;
        resp_err_d      = resp_err_q;
        dm_direccion_d  = dm_direccion_q;
        dm_dataWrite_d  = dm_dataWrite_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    off_d        = req_off_s;
                    size_d       = bus.req_size;
                    signed_d     = bus.req_signed;
                    wdata_d      = bus.req_wdata;
                    resp_rdata_d = 64'h0;
                    resp_err_d   = err_s;
                    if (err_s) begin
                        state_d = RESP;
                    end else begin
                        dm_direccion_d = bus.req_addr[14:3];
                        if (!bus.req_we) begin
                            state_d = LOAD;
                        end else if (bus.req_size == 2'd3) begin
                            dm_dataWrite_d = bus.req_wdata;
                            state_d        = WRITE;
                        end else begin
                            state_d = RD_OLD;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                resp_rdata_d = extend(dm_dataRead >> {off_q, 3'b000}, size_q, signed_q);
                state_d      = RESP;
            end
            RD_OLD: begin
                // Old word keeps every lane except the ones being stored.
                dm_dataWrite_d = (dm_dataRead & ~expand_mask(lane_mask(size_q, off_q))) |
                                 ((wdata_q << {off_q, 3'b000}) &
                                  expand_mask(lane_mask(size_q, off_q)));
                state_d        = WRITE;
            end
            WRITE: begin
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_ready_d     = (state_d == IDLE);
        resp_valid_d    = (state_d == RESP);
        dm_bitAddress_d = (state_d == LOAD) || (state_d == RD_OLD) || (state_d == WRITE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            off_q           <= 3'b000;
            size_q          <= 2'b00;
            signed_q        <= 1'b0;
            wdata_q         <= 64'h0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 64'h0;
            resp_err_q      <= 1'b0;
            dm_direccion_q  <= 12'h000;
            dm_dataWrite_q  <= 64'h0;
            dm_bitAddress_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            off_q           <= off_d;
            size_q          <= size_d;
            signed_q        <= signed_d;
            wdata_q         <= wdata_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_err_q      <= resp_err_d;
            dm_direccion_q  <= dm_direccion_d;
            dm_dataWrite_q  <= dm_dataWrite_d;
            dm_bitAddress_q <= dm_bitAddress_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign dm_direccion   = dm_direccion_q;
    assign dm_dataWrite   = dm_dataWrite_q;
    assign dm_bitAddress  = dm_bitAddress_q;
    // Write strobe is killed immediately by reset so a reset edge never commits a write.
    assign dm_enableWr    = (state_q == WRITE) && rst_n;

endmodule
